instruction_memory_loader: RTL and testbench

INSTRUCTION_MEMORY_LOADER -- requirements
Module: instruction_memory_loader

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_ram.sv | 28 ++
 rtl/instruction_memory_loader.sv | 130 +++++++++++++
 tb/tb_instruction_memory_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory loader.
// The optional bounds check is enabled by defining IMEM_BOUNDS_CHECK_EN.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_e;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int imem_aw(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port-write / single-port-read instruction store with a registered read.
// Contents are deliberately not reset so the array maps onto block RAM.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 150,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Loads a program over a valid/ready stream, then serves single-cycle-latency fetches.
// Define IMEM_BOUNDS_CHECK_EN to flag fetches beyond the loaded program with fault.
module instruction_memory_loader
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 20,
  parameter int                DEPTH    = 150,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] instruction,
  output logic              fault
);

  localparam int AW = imem_aw(DEPTH);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_LOAD = LOAD;
  localparam logic [1:0] S_RUN  = RUN;

  logic [1:0]        state_reg, state_next;
  logic [AW-1:0]     wptr_reg;
  logic              load_done_reg;
  logic              fetch_valid_reg;
  logic              have_data_reg;
  logic              nop_reg;
  logic              load_beat, load_end, load_begin;
  logic              fetch_accept;
  logic              addr_oob, bad_fetch;
  logic [DATA_W-1:0] ram_rdata;

  assign load_ready   = (state_reg == S_LOAD);
  assign fetch_ready  = (state_reg == S_RUN);
  assign load_beat    = load_valid && load_ready;
  assign load_begin   = load_start && (state_reg != S_LOAD);
  assign load_end     = load_beat && (load_last || (wptr_reg == AW'(DEPTH - 1)));
  assign fetch_accept = fetch_req && fetch_ready;
  assign addr_oob     = ({1'b0, fetch_addr} >= (ADDR_W + 1)'(DEPTH));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_RUN: if (load_start) state_next = S_LOAD;
      S_LOAD:        if (load_end) state_next = S_RUN;
      default:       state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      wptr_reg        <= '0;
      load_done_reg   <= 1'b0;
      fetch_valid_reg <= 1'b0;
      have_data_reg   <= 1'b0;
      nop_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      load_done_reg   <= load_end;
      fetch_valid_reg <= fetch_accept;
      if (load_begin) begin
        wptr_reg <= '0;
      end else if (load_beat) begin
        wptr_reg <= wptr_reg + 1'b1;
      end
      // Response selection is captured with the fetch so the output holds between fetches.
      if (fetch_accept) begin
        have_data_reg <= 1'b1;
        nop_reg       <= bad_fetch;
      end
    end
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam int CW = imem_aw(DEPTH + 1);

  logic [CW-1:0] loaded_count_reg;
  logic          fault_reg;

  assign bad_fetch = addr_oob || ({1'b0, fetch_addr} >= (ADDR_W + 1)'(loaded_count_reg));
  assign fault     = fault_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_count_reg <= '0;
      fault_reg        <= 1'b0;
    end else begin
      if (load_begin) begin
        loaded_count_reg <= '0;
      end else if (load_beat) begin
        loaded_count_reg <= loaded_count_reg + 1'b1;
      end
      fault_reg <= fetch_accept && bad_fetch;
    end
  end
`else
  assign bad_fetch = addr_oob;
  assign fault     = 1'b0;
`endif

  imem_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk  (clk),
    .we   (load_beat),
    .waddr(wptr_reg),
    .wdata(load_data),
    .re   (fetch_accept && !addr_oob),
    .raddr(fetch_addr[AW-1:0]),
    .rdata(ram_rdata)
  );

  assign load_done   = load_done_reg;
  assign fetch_valid = fetch_valid_reg;
  assign instruction = !have_data_reg ? '0 : (nop_reg ? NOP_WORD : ram_rdata);

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader with a cycle-level reference model.
// Build with IMEM_BOUNDS_CHECK_EN defined to exercise the fault path.
module tb_instruction_memory_loader;

  localparam int DEPTH = 150;
  localparam logic [31:0] NOP = 32'h0;
`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready, load_done;
  logic        fetch_req = 1'b0;
  logic [19:0] fetch_addr = '0;
  logic        fetch_ready, fetch_valid;
  logic [31:0] instruction;
  logic        fault;

  int total = 0;
  int bad = 0;

  instruction_memory_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .instruction(instruction),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 loading, 2 running.
  logic [31:0] m_mem [DEPTH];
  int          m_mode = 0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic        m_fv = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_instr = '0;

  task automatic model_step();
    int a;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_done = 1'b0; m_fv = 1'b0; m_fault = 1'b0; m_instr = '0;
      return;
    end
    m_fv = (m_mode == 2) && fetch_req;
    m_fault = 1'b0;
    if (m_fv) begin
      a = int'(fetch_addr);
      if (a >= DEPTH) m_instr = NOP;
      else m_instr = m_mem[a];
      if (BC && (a >= DEPTH || a >= m_cnt)) begin
        m_instr = NOP;
        m_fault = 1'b1;
      end
    end
    m_done = 1'b0;
    if (m_mode == 1) begin
      if (load_valid) begin
        m_mem[m_cnt] = load_data;
        m_cnt++;
        if (load_last || m_cnt == DEPTH) begin
          m_mode = 2;
          m_done = 1'b1;
        end
      end
    end else if (load_start) begin
      m_mode = 1;
      m_cnt = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_load_ready", 32'(load_ready), 0);
      chk("rst_fetch_valid", 32'(fetch_valid), 0);
      chk("rst_instruction", instruction, 0);
    end else begin
      chk("m_load_ready", 32'(load_ready), 32'(m_mode == 1));
      chk("m_fetch_ready", 32'(fetch_ready), 32'(m_mode == 2));
      chk("m_load_done", 32'(load_done), 32'(m_done));
      chk("m_fetch_valid", 32'(fetch_valid), 32'(m_fv));
      chk("m_instruction", instruction, m_instr);
      if (m_fv) chk("m_fault", 32'(fault), 32'(m_fault));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seq(input int n, input logic [31:0] base, input logic [31:0] step,
                          input bit use_last, input bit hold_fetch);
    load_start = 1'b1;
    fetch_req  = hold_fetch;
    fetch_addr = '0;
    tick();
    load_start = 1'b0;
    chk("load_ready_on_entry", 32'(load_ready), 1);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + 32'(i) * step;
      load_last  = use_last && (i == n - 1);
      if (i == n - 1) fetch_req = 1'b0;
      tick();
      if (hold_fetch) begin
        chk("load_fetch_valid", 32'(fetch_valid), 0);
        if (i < n - 1) chk("load_fetch_ready", 32'(fetch_ready), 0);
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("load_done_pulse", 32'(load_done), 1);
  endtask

  task automatic fetch_one(input logic [19:0] addr, input logic [31:0] exp, input bit exp_fault);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req = 1'b0;
    chk("fetch_valid", 32'(fetch_valid), 1);
    chk("fetch_instr", instruction, exp);
    chk("fetch_fault", 32'(fault), 32'(exp_fault));
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_load_ready", 32'(load_ready), 0);
    chk("reset_load_done", 32'(load_done), 0);
    chk("reset_fetch_ready", 32'(fetch_ready), 0);
    chk("reset_fetch_valid", 32'(fetch_valid), 0);
    chk("reset_instruction", instruction, 0);
    chk("reset_fault", 32'(fault), 0);
    rst_n = 1'b1;

    // Fetch requests in IDLE are ignored.
    fetch_req = 1'b1;
    fetch_addr = 20'd0;
    repeat (3) begin
      tick();
      chk("idle_fetch_ready", 32'(fetch_ready), 0);
      chk("idle_fetch_valid", 32'(fetch_valid), 0);
    end
    fetch_req = 1'b0;

    // Three-word program, back-to-back fetches.
    load_seq(3, 32'h11, 32'h11, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = 20'(i);
      tick();
      if (i == 0) chk("done_one_cycle", 32'(load_done), 0);
      chk("b2b_valid", 32'(fetch_valid), 1);
      chk("b2b_instr", instruction, 32'h11 * 32'(i + 1));
    end
    fetch_req = 1'b0;
    tick();
    chk("idle_after_fetch_valid", 32'(fetch_valid), 0);
    chk("instr_holds", instruction, 32'h33);

    // Full-depth load ends automatically on the last address.
    load_seq(DEPTH, 32'hA000_0000, 32'h1, 1'b0, 1'b0);
    fetch_one(20'd149, 32'hA000_0095, 1'b0);
    fetch_one(20'd150, NOP, BC);
    fetch_one(20'hFFFFF, NOP, BC);

    // Short reload; fetches beyond it depend on the bounds check.
    load_seq(5, 32'hB000_0000, 32'h1, 1'b1, 1'b0);
    fetch_one(20'd7, BC ? NOP : 32'hA000_0007, BC);
    fetch_one(20'd4, 32'hB000_0004, 1'b0);

    // Asynchronous reset in the middle of a load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = 32'hC000_0000 + 32'(i);
      tick();
    end
    chk("pre_reset_load_ready", 32'(load_ready), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_load_ready", 32'(load_ready), 0);
    chk("async_fetch_ready", 32'(fetch_ready), 0);
    chk("async_fetch_valid", 32'(fetch_valid), 0);
    chk("async_instruction", instruction, 0);
    chk("async_load_done", 32'(load_done), 0);
    chk("async_fault", 32'(fault), 0);
    load_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    load_seq(1, 32'hAB, 32'h0, 1'b1, 1'b1);
    fetch_one(20'd0, 32'hAB, 1'b0);

    // Reload requested in the same cycle as a fetch: old word first, then LOAD.
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 20'd0;
    tick();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    chk("overlap_fetch_valid", 32'(fetch_valid), 1);
    chk("overlap_old_word", instruction, 32'hAB);
    chk("overlap_load_ready", 32'(load_ready), 1);
    load_valid = 1'b1;
    load_data  = 32'hCD;
    load_last  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("overlap_load_done", 32'(load_done), 1);
    fetch_one(20'd0, 32'hCD, 1'b0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
